dcache_write_ctrl: RTL
======================

Name: dcache_write_ctrl

Overview:
Store-side controller for the data cache. It owns the 8-line x 4-byte direct-mapped cache array (data, tag, valid, dirty) and merges CPU byte stores into the block at the addressed byte offset. The cache is write-allocate and write-back, with a handshake to block-wide data memory. The read side gets a full block plus tag and valid through the rd_* port; byte selection by offset is done outside this block.

Parameters:
NUM_LINES, 8, cache lines (index width = log2 = 3)
TAG_W, 3, tag width; address = {tag[2:0], index[2:0], offset[1:0]}

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
write  input  1  CPU store request, held until busywait low
address  input  8  CPU byte address
writedata  input  8  CPU store byte
busywait  output  1  CPU stall
rd_index  input  3  read-side line select
rd_block  output  32  data of line rd_index; byte k = bits 8k+7:8k
rd_tag  output  3  tag of line rd_index
rd_valid  output  1  valid bit of line rd_index
mem_read  output  1  block fetch request
mem_write  output  1  block write-back request
mem_address  output  6  block address {tag,index}
mem_writedata  output  32  victim block
mem_readdata  input  32  fetched block
mem_busywait  input  1  memory busy

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. At the first edge with reset=1:
  - state = IDLE;
  - all valid/dirty = 0, all data/tag = 0;
  - mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0.
- Reset overrides everything, including a transaction in flight. After reset, busywait=0 while write=0.
- rd_block, rd_tag, rd_valid: combinational reads of the array at rd_index. They reflect updates from the edge after each write.
- Hit: hit = valid[idx] && tag[idx]==address[7:5].
- busywait (combinational):
  - 1 when write && (state!=IDLE || !hit);
  - 0 in UPDATE;
  - 0 otherwise.
- States:
  - IDLE:
    - write && hit: merge writedata into byte lane address[1:0] and set dirty at this edge. Zero stall cycles.
    - write && miss: latch address and writedata, then go to WRITEBACK if the victim is valid && dirty, else FETCH.
  - WRITEBACK:
    - mem_write=1; mem_address={victim tag, idx}; mem_writedata = victim block.
    - On completion, go to FETCH.
  - FETCH:
    - mem_read=1; mem_address = {latched tag, idx}.
    - On completion: data[idx]=mem_readdata, tag=latched tag, valid=1, dirty=0; go to UPDATE.
  - UPDATE: merge the latched byte at the latched offset, dirty=1, go to IDLE. busywait=0 this cycle, so the CPU retires at this edge.
- Memory handshake:
  - A request is asserted and held constant from the edge its state is entered.
  - The transfer completes at the first rising edge where the request is high and mem_busywait=0, excluding the request's first cycle.
  - Minimum 2 cycles per transfer.
  - mem_read and mem_write are never both 1, and each drops at the completion edge.
- Byte merge: only lane address[1:0] changes; the other 3 bytes are preserved.
- A CPU that drops write mid-miss still gets the fetch completed. The UPDATE merge uses latched values, so CPU input changes while busywait=1 are ignored.
- Writes to different indices never disturb other lines.

Test Plan:
1. Cold miss, clean.
   - Stimulus: reset; write address 0xA9 (tag5, idx2, off1), data 0x3C; memory busy 3 cycles, then returns 0x44332211.
   - Response: single mem_read at mem_address 0x2A, no mem_write. rd_index=2 gives block 0x44333C11, tag 5, valid 1. busywait low at the UPDATE edge.
2. Write hit.
   - Stimulus: write 0xAB (off3), data 0x7E.
   - Response: busywait never high, no memory request. Block becomes 0x7E333C11 on the next edge.
3. Dirty conflict.
   - Stimulus: write 0x29 (tag1, idx2, off1), data 0x55.
   - Response: mem_write with address 0x2A, data 0x7E333C11. Then mem_read with address 0x0A, returning 0xDDCCBBAA. Final block 0xDDCC55AA, tag 1, dirty.
4. Reset mid-FETCH.
   - Stimulus: assert reset for one cycle while mem_read=1.
   - Response: next cycle mem_read=0, busywait=0, rd_valid=0 for every index. A later write to 0x29 performs a fetch only, with no write-back.
5. Zero-wait memory.
   - Stimulus: mem_busywait tied 0; miss to 0x04 (idx1, off0), data 0xEE, memory returns 0x00000000.
   - Response: FETCH lasts exactly 2 cycles. Block = 0x000000EE.
6. Lane coverage and isolation.
   - Stimulus: hits to offsets 0..3 of line 1 with data 0x01, 0x02, 0x03, 0x04.
   - Response: block 0x04030201. Lines 0 and 2..7 unchanged.

Source files
------------

// File: rtl/dcache_write_ctrl.sv
// Store-side controller for a direct-mapped, write-allocate, write-back data cache.
// It owns the line array, merges CPU byte stores, and runs the block write-back/fetch handshake.
module dcache_write_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int TAG_W     = 3,
    localparam int IDX_W    = $clog2(NUM_LINES),
    localparam int ADDR_W   = TAG_W + IDX_W + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      address,
    input  logic [7:0]             writedata,
    output logic                   busywait,
    input  logic [IDX_W-1:0]       rd_index,
    output logic [31:0]            rd_block,
    output logic [TAG_W-1:0]       rd_tag,
    output logic                   rd_valid,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [TAG_W+IDX_W-1:0] mem_address,
    output logic [31:0]            mem_writedata,
    input  logic [31:0]            mem_readdata,
    input  logic                   mem_busywait
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [31:0]              data_r [NUM_LINES];
    logic [TAG_W-1:0]         tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0]     valid_r;
    logic [NUM_LINES-1:0]     dirty_r;
    logic [ADDR_W-1:0]        lat_addr_r;
    logic [7:0]               lat_data_r;
    logic                     req_first_r, req_first_nxt_s;
    logic                     mem_read_nxt_s, mem_write_nxt_s;
    logic [TAG_W+IDX_W-1:0]   mem_address_nxt_s;
    logic [31:0]              mem_writedata_nxt_s;

    logic [IDX_W-1:0]         cpu_idx_s, lat_idx_s;
    logic [TAG_W-1:0]         cpu_tag_s, lat_tag_s;
    logic                     hit_s;
    logic                     xfer_done_s;

    // Replace one byte lane of a block, keeping the other three lanes.
    function automatic logic [31:0] merge_byte(input logic [31:0] blk,
                                               input logic [1:0]  off,
                                               input logic [7:0]  b);
        logic [31:0] res;
        res = blk;
        res[{off, 3'b000} +: 8] = b;
        return res;
    endfunction

    assign cpu_idx_s = address[IDX_W+1:2];
    assign cpu_tag_s = address[ADDR_W-1:IDX_W+2];
    assign lat_idx_s = lat_addr_r[IDX_W+1:2];
    assign lat_tag_s = lat_addr_r[ADDR_W-1:IDX_W+2];
    assign hit_s     = valid_r[cpu_idx_s] && (tag_r[cpu_idx_s] == cpu_tag_s);

    // A transfer may only complete after its first request cycle.
    assign xfer_done_s = (mem_read || mem_write) && !req_first_r && !mem_busywait;

    assign rd_block = data_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_valid = valid_r[rd_index];

    // CPU stall: misses and in-flight transactions stall, UPDATE lets the store retire.
    always_comb begin
        busywait = 1'b0;
        if (state_r == ST_UPDATE) begin
            busywait = 1'b0;
        end else begin
            busywait = write && ((state_r != ST_IDLE) || !hit_s);
        end
    end

    // Next state and next values of the registered memory request outputs.
    always_comb begin
        state_nxt_s         = state_r;
        mem_read_nxt_s      = mem_read;
        mem_write_nxt_s     = mem_write;
        mem_address_nxt_s   = mem_address;
        mem_writedata_nxt_s = mem_writedata;
        req_first_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (write && !hit_s) begin
                    req_first_nxt_s = 1'b1;
                    if (valid_r[cpu_idx_s] && dirty_r[cpu_idx_s]) begin
                        state_nxt_s         = ST_WRITEBACK;
                        mem_write_nxt_s     = 1'b1;
                        mem_address_nxt_s   = {tag_r[cpu_idx_s], cpu_idx_s};
                        mem_writedata_nxt_s = data_r[cpu_idx_s];
                    end else begin
                        state_nxt_s       = ST_FETCH;
                        mem_read_nxt_s    = 1'b1;
                        mem_address_nxt_s = {cpu_tag_s, cpu_idx_s};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (xfer_done_s) begin
                    state_nxt_s       = ST_FETCH;
                    mem_write_nxt_s   = 1'b0;
                    mem_read_nxt_s    = 1'b1;
                    mem_address_nxt_s = {lat_tag_s, lat_idx_s};
                    req_first_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WRITEBACK;
                end
            end
            ST_FETCH: begin
                if (xfer_done_s) begin
                    state_nxt_s    = ST_UPDATE;
                    mem_read_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_UPDATE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                mem_read_nxt_s  = 1'b0;
                mem_write_nxt_s = 1'b0;
            end
        endcase
    end

    // State register and registered memory request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            req_first_r   <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= 32'h0000_0000;
        end else begin
            state_r       <= state_nxt_s;
            req_first_r   <= req_first_nxt_s;
            mem_read      <= mem_read_nxt_s;
            mem_write     <= mem_write_nxt_s;
            mem_address   <= mem_address_nxt_s;
            mem_writedata <= mem_writedata_nxt_s;
        end
    end

    // Line array updates and capture of the missing store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                data_r[i] <= 32'h0000_0000;
                tag_r[i]  <= '0;
            end
            valid_r    <= '0;
            dirty_r    <= '0;
            lat_addr_r <= '0;
            lat_data_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (write && hit_s) begin
                        data_r[cpu_idx_s]  <= merge_byte(data_r[cpu_idx_s], address[1:0], writedata);
                        dirty_r[cpu_idx_s] <= 1'b1;
                    end else if (write) begin
                        lat_addr_r <= address;
                        lat_data_r <= writedata;
                    end else begin
                        lat_addr_r <= lat_addr_r;
                    end
                end
                ST_FETCH: begin
                    if (xfer_done_s) begin
                        data_r[lat_idx_s]  <= mem_readdata;
                        tag_r[lat_idx_s]   <= lat_tag_s;
                        valid_r[lat_idx_s] <= 1'b1;
                        dirty_r[lat_idx_s] <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    data_r[lat_idx_s]  <= merge_byte(data_r[lat_idx_s], lat_addr_r[1:0], lat_data_r);
                    dirty_r[lat_idx_s] <= 1'b1;
                end
                default: begin
                    lat_addr_r <= lat_addr_r;
                end
            endcase
        end
    end

endmodule
